// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the hazard controller: forward selects, FSM state type and the x0 index.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t RUN      = 1'b0;
  localparam state_t MEM_WAIT = 1'b1;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_controller_fwd_sel.sv
// One execute-operand forward select; the memory stage wins over writeback, x0 never forwards.
module fwd_sel (
  input  logic       i_regWriteM,
  input  logic [4:0] i_rdM,
  input  logic       i_regWriteW,
  input  logic [4:0] i_rdW,
  input  logic [4:0] i_rsE,
  output logic [1:0] o_fwd
);
  import hazard_pkg::*;

  always_comb begin
    o_fwd = FWD_RF;
    if (i_regWriteM && (i_rdM != REG_X0) && (i_rdM == i_rsE))
      o_fwd = FWD_M;
    else if (i_regWriteW && (i_rdW != REG_X0) && (i_rdW == i_rsE))
      o_fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, memory freeze with timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rd_D,
  input  logic       RegWrite_D,
  input  logic       Load_D,
  input  logic       PcSrc_E,
  input  logic       MemAccess_M,
  input  logic       MemReady_M,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       MemError
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);
  import hazard_pkg::*;

  localparam int            CW      = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT - 1);

  logic [4:0]    r_rs1E, r_rs2E, r_rdE, r_rdM, r_rdW;
  logic          r_regWriteE, r_loadE, r_regWriteM, r_regWriteW;
  state_t        r_state;
  logic [CW-1:0] r_waitCnt;
  logic          r_memError;
  logic          w_frz, w_lwStall, w_timeoutHit;
  logic [1:0]    w_fwdA, w_fwdB;

  assign w_frz        = MemAccess_M && !MemReady_M;
  assign w_lwStall    = r_loadE && (r_rdE != REG_X0) && ((r_rdE == Rs1_D) || (r_rdE == Rs2_D));
  assign w_timeoutHit = !reset && (r_state == MEM_WAIT) && w_frz && (r_waitCnt == CNT_MAX);
  assign MemError     = r_memError || w_timeoutHit;

  fwd_sel u_fwdA (
    .i_regWriteM(r_regWriteM), .i_rdM(r_rdM),
    .i_regWriteW(r_regWriteW), .i_rdW(r_rdW),
    .i_rsE(r_rs1E), .o_fwd(w_fwdA)
  );

  fwd_sel u_fwdB (
    .i_regWriteM(r_regWriteM), .i_rdM(r_rdM),
    .i_regWriteW(r_regWriteW), .i_rdW(r_rdW),
    .i_rsE(r_rs2E), .o_fwd(w_fwdB)
  );

  // Priority: reset, then memory freeze, then branch redirect over load-use.
  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    ForwardA_E = w_fwdA;
    ForwardB_E = w_fwdB;
    if (reset) begin
      FlushD     = 1'b1;
      FlushE     = 1'b1;
      FlushW     = 1'b1;
      ForwardA_E = FWD_RF;
      ForwardB_E = FWD_RF;
    end else if (w_frz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      FlushD = PcSrc_E;
      FlushE = PcSrc_E || w_lwStall;
      StallF = w_lwStall && !PcSrc_E;
      StallD = w_lwStall && !PcSrc_E;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1E      <= REG_X0;
      r_rs2E      <= REG_X0;
      r_rdE       <= REG_X0;
      r_regWriteE <= 1'b0;
      r_loadE     <= 1'b0;
      r_rdM       <= REG_X0;
      r_regWriteM <= 1'b0;
      r_rdW       <= REG_X0;
      r_regWriteW <= 1'b0;
    end else if (StallE) begin
      r_rdW       <= REG_X0;
      r_regWriteW <= 1'b0;
    end else begin
      r_rdW       <= r_rdM;
      r_regWriteW <= r_regWriteM;
      r_rdM       <= r_rdE;
      r_regWriteM <= r_regWriteE;
      if (FlushE) begin
        r_rs1E      <= REG_X0;
        r_rs2E      <= REG_X0;
        r_rdE       <= REG_X0;
        r_regWriteE <= 1'b0;
        r_loadE     <= 1'b0;
      end else begin
        r_rs1E      <= Rs1_D;
        r_rs2E      <= Rs2_D;
        r_rdE       <= Rd_D;
        r_regWriteE <= RegWrite_D;
        r_loadE     <= Load_D;
      end
    end
  end

  // wait_cnt holds the number of the current frozen cycle minus one; entering MEM_WAIT already counts one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_waitCnt  <= '0;
      r_memError <= 1'b0;
    end else begin
      if (w_timeoutHit)
        r_memError <= 1'b1;
      case (r_state)
        RUN: begin
          if (w_frz) begin
            r_state   <= MEM_WAIT;
            r_waitCnt <= CW'(1);
          end
        end
        default: begin
          if (!w_frz) begin
            r_state   <= RUN;
            r_waitCnt <= '0;
          end else if (r_waitCnt != CNT_MAX) begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCount, r_flushCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (StallF)
        r_stallCount <= r_stallCount + 32'd1;
      if (FlushD)
        r_flushCount <= r_flushCount + 32'd1;
    end
  end

  assign StallCount = r_stallCount;
  assign FlushCount = r_flushCount;
`endif

endmodule
